// File: rtl/regfile_dump.sv
// LEGv8 32xN register file (X31 reads zero) with a valid/ready dump streamer for end-of-run state checks.
// Reads are combinational. A dump beat holds while dump_ready is low, and the first beat is valid one cycle after start.
module regfile_dump #(
    parameter int N          = 64,
    parameter bit RESET_INIT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    input  logic         we3,
    input  logic [4:0]   wa3,
    input  logic [N-1:0] wd3,
    input  logic         dump_start,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [4:0]   dump_idx,
    output logic [N-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [N-1:0] r_regs [0:30];
    logic [N-1:0] w_regs [0:31];
    state_t       r_state;
    logic         r_valid;
    logic [4:0]   r_idx;
    logic [N-1:0] r_data;
    logic         r_busy;
    logic         r_done;
    logic [4:0]   w_nidx;
    logic         w_xfer;
    logic [N-1:0] w_snap0;
    logic [N-1:0] w_snapn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 31; i++) begin
                r_regs[i] <= RESET_INIT ? N'(i) : '0;
            end
        end else begin
            for (int i = 0; i < 31; i++) begin
                if (we3 && (wa3 == 5'(i))) begin
                    r_regs[i] <= wd3;
                end
            end
        end
    end

    // Slot 31 is XZR; it lets every 5-bit address index the view directly.
    always_comb begin
        for (int i = 0; i < 31; i++) begin
            w_regs[i] = r_regs[i];
        end
        w_regs[31] = '0;
    end

    assign rd1 = w_regs[ra1];
    assign rd2 = w_regs[ra2];

    assign w_nidx = r_idx + 5'd1;
    assign w_xfer = r_valid && dump_ready;

    // Snapshot loads forward a same-edge write so the dump never misses it.
    assign w_snap0 = (we3 && wa3 == 5'd0) ? wd3 : w_regs[0];
    assign w_snapn = (we3 && wa3 == w_nidx && w_nidx != 5'd31) ? wd3 : w_regs[w_nidx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dump_start) begin
                        r_state <= ST_SCAN;
                        r_valid <= 1'b1;
                        r_idx   <= '0;
                        r_data  <= w_snap0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_xfer) begin
                        if (r_idx == 5'd31) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= w_nidx;
                            r_data <= w_snapn;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dump_valid = r_valid;
    assign dump_idx   = r_idx;
    assign dump_data  = r_data;
    assign dump_busy  = r_busy;
    assign dump_done  = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed stimulus pushes expected dump beats, and a negedge monitor pops and compares accepted beats.
module tb_regfile_dump;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic [4:0]   ra1, ra2, wa3;
    logic [N-1:0] rd1, rd2, wd3;
    logic         we3;
    logic         dump_start, dump_valid, dump_ready, dump_busy, dump_done;
    logic [4:0]   dump_idx;
    logic [N-1:0] dump_data;

    typedef struct {
        logic [4:0]   idx;
        logic [N-1:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [N-1:0] exp_regs [0:30];
    int           n_checks = 0;
    int           n_pass   = 0;

    regfile_dump #(.N(N), .RESET_INIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Accepted beats are compared against the head of the expectation queue.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {59'd0, dump_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_idx", {59'd0, dump_idx}, {59'd0, b.idx});
                    chk("beat_data", dump_data, b.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        beat_t b;
        for (int i = 0; i < 32; i++) begin
            b.idx  = 5'(i);
            b.data = (i == 31) ? '0 : exp_regs[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic start_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dump_done === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        beat_t b;
        reset = 1'b0; ra1 = 5'd5; ra2 = 5'd31; we3 = 1'b0; wa3 = '0; wd3 = '0;
        dump_start = 1'b0; dump_ready = 1'b1;
        for (int i = 0; i < 31; i++) exp_regs[i] = N'(i);

        #12;
        chk("rst_valid", {63'd0, dump_valid}, 64'd0);
        chk("rst_busy", {63'd0, dump_busy}, 64'd0);
        chk("rst_done", {63'd0, dump_done}, 64'd0);
        chk("rst_idx", {59'd0, dump_idx}, 64'd0);
        chk("rst_data", dump_data, 64'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rd1_r5", rd1, 64'd5);
        chk("rd2_xzr", rd2, 64'd0);

        tick();
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'hDEAD_BEEF; ra1 = 5'd3;
        @(negedge clk);
        chk("no_bypass", rd1, 64'd3);
        tick();
        we3 = 1'b0;
        exp_regs[3] = 64'hDEAD_BEEF;
        @(negedge clk);
        chk("write_r3", rd1, 64'hDEAD_BEEF);

        tick();
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'd7;
        tick();
        we3 = 1'b0; ra1 = 5'd31;
        @(negedge clk);
        chk("xzr_write", rd1, 64'd0);
        for (int i = 0; i < 31; i++) begin
            ra2 = 5'(i);
            #1;
            chk("regs_intact", rd2, exp_regs[i]);
        end

        // Full back-to-back dump.
        tick();
        push_all();
        dump_ready = 1'b1;
        start_dump();
        @(negedge clk);
        chk("d_valid_lat", {63'd0, dump_valid}, 64'd1);
        chk("d_busy", {63'd0, dump_busy}, 64'd1);
        wait_done(cyc);
        chk("d_cycles", 64'(cyc), 64'd32);
        chk("d_busy_done", {63'd0, dump_busy}, 64'd1);
        @(negedge clk);
        chk("d_done_pulse", {63'd0, dump_done}, 64'd0);
        chk("d_busy_low", {63'd0, dump_busy}, 64'd0);
        chk("d_q_empty", 64'(exp_q.size()), 64'd0);

        // Stall at idx 4 with writes to reg4 and reg5.
        tick();
        for (int i = 0; i < 32; i++) begin
            b.idx  = 5'(i);
            b.data = (i == 31) ? '0 : (i == 5) ? 64'hAA : exp_regs[i];
            exp_q.push_back(b);
        end
        start_dump();
        for (int c = 0; c < 10 && dump_idx !== 5'd4; c++) tick();
        dump_ready = 1'b0; we3 = 1'b1; wa3 = 5'd4; wd3 = 64'h55;
        tick();
        we3 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("stall_idx", {59'd0, dump_idx}, 64'd4);
        chk("stall_data", dump_data, 64'd4);
        chk("stall_valid", {63'd0, dump_valid}, 64'd1);
        @(posedge clk);
        #1;
        dump_ready = 1'b1; we3 = 1'b1; wa3 = 5'd5; wd3 = 64'hAA;
        tick();
        we3 = 1'b0;
        exp_regs[4] = 64'h55;
        exp_regs[5] = 64'hAA;
        wait_done(cyc);
        chk("stall_done", {63'd0, dump_done}, 64'd1);
        chk("stall_q_empty", 64'(exp_q.size()), 64'd0);
        tick();
        tick();

        // Reset in the middle of a dump.
        for (int i = 0; i < 10; i++) begin
            b.idx  = 5'(i);
            b.data = exp_regs[i];
            exp_q.push_back(b);
        end
        start_dump();
        for (int c = 0; c < 20 && dump_idx !== 5'd10; c++) tick();
        reset = 1'b0;
        ra1 = 5'd3;
        #1;
        chk("abort_valid", {63'd0, dump_valid}, 64'd0);
        chk("abort_busy", {63'd0, dump_busy}, 64'd0);
        chk("abort_r3", rd1, 64'd3);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_idle_valid", {63'd0, dump_valid}, 64'd0);
        chk("abort_idx", {59'd0, dump_idx}, 64'd0);
        chk("abort_q_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
